// File: rtl/srio_hello_pkg.sv
// Shared HELLO-format definitions for the SRIO doorbell path: type codes, field positions, FSM states.
// Pure definitions, no latency or flow control of its own.
package srio_hello_pkg;

    localparam logic [7:0] FTYPE_DOORB       = 8'hA0;
    localparam logic [7:0] FTYPE_RESP_NODATA = 8'hD0;

    localparam int TID_MSB  = 63;
    localparam int TID_LSB  = 56;
    localparam int TYPE_MSB = 55;
    localparam int TYPE_LSB = 48;
    localparam int PRIO_MSB = 46;
    localparam int PRIO_LSB = 45;
    localparam int CRF_BIT  = 44;
    localparam int INFO_MSB = 31;
    localparam int INFO_LSB = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        DROP = 2'd2
    } db_state_t;

    // Responses go out one priority level above the request so they cannot be blocked by it.
    function automatic logic [63:0] resp_hdr(input logic [7:0] tid, input logic [1:0] prio,
                                             input logic crf);
        logic [1:0] rprio;
        rprio = (prio == 2'd3) ? 2'd3 : prio + 2'd1;
        return {tid, FTYPE_RESP_NODATA, 1'b0, rprio, crf, 44'b0};
    endfunction

endpackage

// File: rtl/db_info_fifo.sv
// First-word-fall-through queue of {src_id, info}; head valid 1 cycle after push.
// Push is ignored when full unless a pop happens in the same cycle; pop is ignored when empty.
module db_info_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    // Head reads as zero while empty so user logic never sees stale entries.
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push_en) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/doorbell_target.sv
// Target-side RapidIO doorbell handler: queues {src_id, info} and answers each doorbell with RESPONSE-no-data.
// Response and queue head valid 1 cycle after accept; treq stalls while responding or while the queue is full.
module doorbell_target
    import srio_hello_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        s_axis_treq_tvalid,
    output logic        s_axis_treq_tready,
    input  logic [63:0] s_axis_treq_tdata,
    input  logic [7:0]  s_axis_treq_tkeep,
    input  logic        s_axis_treq_tlast,
    input  logic [31:0] s_axis_treq_tuser,
    output logic        m_axis_tresp_tvalid,
    input  logic        m_axis_tresp_tready,
    output logic [63:0] m_axis_tresp_tdata,
    output logic [7:0]  m_axis_tresp_tkeep,
    output logic        m_axis_tresp_tlast,
    output logic [31:0] m_axis_tresp_tuser,
    output logic        db_valid,
    input  logic        db_ready,
    output logic [15:0] db_info,
    output logic [15:0] db_src_id,
    output logic [15:0] drop_count
);

    db_state_t   state;
    db_state_t   state_nxt;
    logic        is_doorb;
    logic        fifo_push;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;
    logic        resp_load;
    logic        drop_inc;
    logic        unused_ok;

    assign is_doorb = (s_axis_treq_tdata[TYPE_MSB:TYPE_LSB] == FTYPE_DOORB);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        s_axis_treq_tready = 1'b0;
        fifo_push          = 1'b0;
        resp_load          = 1'b0;
        drop_inc           = 1'b0;
        case (state)
            IDLE: begin
                s_axis_treq_tready = !fifo_full;
                if (s_axis_treq_tvalid && !fifo_full) begin
                    if (is_doorb && s_axis_treq_tlast) begin
                        fifo_push = 1'b1;
                        resp_load = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        drop_inc = 1'b1;
                        if (!s_axis_treq_tlast) state_nxt = DROP;
                    end
                end
            end
            RESP: begin
                if (m_axis_tresp_tready) state_nxt = IDLE;
            end
            DROP: begin
                s_axis_treq_tready = 1'b1;
                if (s_axis_treq_tvalid && s_axis_treq_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m_axis_tresp_tvalid = (state == RESP);
    assign m_axis_tresp_tlast  = m_axis_tresp_tvalid;
    assign m_axis_tresp_tkeep  = 8'hFF;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tresp_tdata <= '0;
            m_axis_tresp_tuser <= '0;
        end else if (resp_load) begin
            m_axis_tresp_tdata <= resp_hdr(s_axis_treq_tdata[TID_MSB:TID_LSB],
                                           s_axis_treq_tdata[PRIO_MSB:PRIO_LSB],
                                           s_axis_treq_tdata[CRF_BIT]);
            m_axis_tresp_tuser <= {s_axis_treq_tuser[15:0], s_axis_treq_tuser[31:16]};
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                                 drop_count <= '0;
        else if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end

    db_info_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_db_info_fifo (
        .aclk     (aclk),
        .areset   (areset),
        .push     (fifo_push),
        .push_dat ({s_axis_treq_tuser[31:16], s_axis_treq_tdata[INFO_MSB:INFO_LSB]}),
        .pop      (db_ready),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign db_valid  = !fifo_empty;
    assign db_src_id = fifo_head[31:16];
    assign db_info   = fifo_head[15:0];

    // Header bits that carry no meaning for a doorbell target.
    assign unused_ok = ^{s_axis_treq_tkeep, s_axis_treq_tdata[47],
                         s_axis_treq_tdata[43:32], s_axis_treq_tdata[15:0]};

endmodule
